countdown_ctrl: RTL

//  Sequences the 5-bit countdown value (0..31 s) and drives the two-digit seven-segment display.
//  - Loads a start value, decrements it once per second, supports pause/resume/stop, and flags expiry.
//  - Drives CD into the countdown-to-segment decoder and takes the two decoded patterns back.
//  - Time-multiplexes those patterns onto one shared segment bus with per-digit enables.

---
 rtl/countdown_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/countdown_ctrl.sv
// Countdown sequencer (0..31 s) with two-digit multiplexed seven-segment scan.
// Optional build macro BLINK_ON_EXPIRE_EN blanks the display on alternate half-seconds in EXPIRED.
module countdown_ctrl #(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [4:0] load_val,
  output logic [4:0] CD,
  input  logic [7:0] CD_show1,
  input  logic [7:0] CD_show2,
  output logic [7:0] seg_out,
  output logic [1:0] seg_en,
  output logic       busy,
  output logic       expired
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state_q;
  logic [4:0]    cd_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          busy_q, expired_q;
  logic          tick_wrap;

  logic [SW-1:0] scan_q, scan_d;
  logic          scan_wrap;
  logic          sel_q;
  logic [7:0]    seg_out_q;
  logic [1:0]    seg_en_q;
  logic          blank;

  assign tick_wrap = (presc_q == PMAX);
  assign presc_d   = tick_wrap ? '0 : presc_q + 1'b1;
  assign scan_wrap = (scan_q == SMAX);
  assign scan_d    = scan_wrap ? '0 : scan_q + 1'b1;

  // The pause edge itself still counts as a RUN cycle, so a pause/resume
  // pair loses no part of the current second.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cd_q      <= '0;
      presc_q   <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else if (stop) begin
      state_q   <= IDLE;
      cd_q      <= '0;
      presc_q   <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else if (start) begin
      cd_q    <= load_val;
      presc_q <= '0;
      if (load_val == 5'd0) begin
        state_q   <= EXPIRED;
        busy_q    <= 1'b0;
        expired_q <= 1'b1;
      end else begin
        state_q   <= RUN;
        busy_q    <= 1'b1;
        expired_q <= 1'b0;
      end
    end else begin
      case (state_q)
        RUN: begin
          presc_q <= presc_d;
          if (tick_wrap && cd_q == 5'd1) begin
            cd_q      <= '0;
            state_q   <= EXPIRED;
            busy_q    <= 1'b0;
            expired_q <= 1'b1;
          end else begin
            if (tick_wrap) cd_q <= cd_q - 5'd1;
            if (pause) state_q <= PAUSE;
          end
        end
        PAUSE: if (pause) state_q <= RUN;
        default: ;
      endcase
    end
  end

`ifdef BLINK_ON_EXPIRE_EN
  logic [PW-1:0] blink_q;
  localparam logic [PW-1:0] HALF = PW'(TICK_DIV / 2);

  always_ff @(posedge clk) begin
    if (rst || stop || start || state_q != EXPIRED) blink_q <= '0;
    else if (blink_q == PMAX)                       blink_q <= '0;
    else                                            blink_q <= blink_q + 1'b1;
  end

  assign blank = (state_q == EXPIRED) && (blink_q >= HALF);
`else
  assign blank = 1'b0;
`endif

  // Display registers sample the decoder, so they trail CD by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q    <= '0;
      sel_q     <= 1'b0;
      seg_out_q <= '0;
      seg_en_q  <= '0;
    end else begin
      scan_q <= scan_d;
      if (scan_wrap) sel_q <= ~sel_q;
      if (blank) begin
        seg_out_q <= '0;
        seg_en_q  <= 2'b00;
      end else if (sel_q) begin
        seg_out_q <= CD_show2;
        seg_en_q  <= 2'b01;
      end else begin
        seg_out_q <= CD_show1;
        seg_en_q  <= 2'b10;
      end
    end
  end

  assign CD      = cd_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign seg_out = seg_out_q;
  assign seg_en  = seg_en_q;

endmodule
